fc_train_sequencer: RTL and testbench

FC_TRAIN_SEQUENCER -- requirements
Module: fc_train_sequencer

---
 rtl/fc_pkg.sv | 36 +++
 rtl/fc_load_ctrl.sv | 52 +++++
 rtl/fc_train_sequencer.sv | 143 ++++++++++++++
 tb/tb_fc_train_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared state encoding and load-address map for the FC training sequencer.
package fc_pkg;

    typedef enum logic [3:0] {
        IDLE, LD_W1, LD_W2, LD_IN, LD_ANS, SETTLE, FWD, BWD, BATCH, ERR
    } fc_state_t;

    localparam logic [15:0] IN_BASE = 16'd0;

    // Each load phase writes a contiguous window starting at its own base.
    function automatic logic [15:0] load_base(input fc_state_t st, input int frt_cell,
                                              input int mid_cell, input int bck_cell);
        case (st)
            LD_W1:   load_base = 16'(frt_cell);
            LD_W2:   load_base = 16'(mid_cell);
            LD_ANS:  load_base = 16'(bck_cell);
            default: load_base = IN_BASE;
        endcase
    endfunction

    function automatic logic [15:0] load_words(input fc_state_t st, input int frt_cell,
                                               input int mid_cell, input int bck_cell);
        case (st)
            LD_W1:   load_words = 16'(frt_cell * mid_cell);
            LD_W2:   load_words = 16'(mid_cell * bck_cell);
            LD_IN:   load_words = 16'(frt_cell);
            LD_ANS:  load_words = 16'(bck_cell);
            default: load_words = 16'd1;
        endcase
    endfunction

    function automatic logic is_load(input fc_state_t st);
        return st inside {LD_W1, LD_W2, LD_IN, LD_ANS};
    endfunction

endpackage

// File: rtl/fc_load_ctrl.sv
// Load-bus generator: one registered FC write per accepted word, 1-cycle latency.
// Backpressure: src_ready drops for one drain cycle after a phase's last word so the write retires in-phase.
module fc_load_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        active,
    input  logic [15:0] base,
    input  logic [15:0] words,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic [15:0] src_data,
    output logic        ex_we,
    output logic [15:0] ex_value,
    output logic [15:0] ex_addr,
    output logic        phase_done
);

    logic [15:0] idx;
    logic        drain;
    logic        xfer;

    assign src_ready  = active && !drain;
    assign xfer       = src_valid && src_ready;
    assign phase_done = drain;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx      <= '0;
            drain    <= 1'b0;
            ex_we    <= 1'b0;
            ex_value <= '0;
            ex_addr  <= '0;
        end else begin
            ex_we <= xfer;
            if (xfer) begin
                ex_value <= src_data;
                ex_addr  <= base + idx;
            end
            // The drain cycle is where the FSM advances, so the index restarts there.
            if (drain) begin
                drain <= 1'b0;
                idx   <= '0;
            end else if (xfer) begin
                if (idx == words - 16'd1)
                    drain <= 1'b1;
                else
                    idx <= idx + 16'd1;
            end
        end
    end

endmodule

// File: rtl/fc_train_sequencer.sv
// Sequences one FC training sample: load weights/inputs/answer, forward, backward, batch update.
// Load words are accepted on src_valid&&src_ready; FC commands hold until their done input or the watchdog fires.
module fc_train_sequencer
    import fc_pkg::*;
#(
    parameter int FRT_CELL   = 14,
    parameter int MID_CELL   = 10,
    parameter int BCK_CELL   = 5,
    parameter int BATCH_SIZE = 32,
    parameter int TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        load_weights,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic [15:0] src_data,
    output logic        ex_we,
    output logic [15:0] ex_value,
    output logic [15:0] ex_addr,
    output logic        weight1,
    output logic        weight2,
    output logic        right_answer,
    output logic        enable,
    output logic        bck_prop_start,
    output logic        batch_end,
    input  logic        all_end,
    input  logic        fc_bck_prop_end,
    input  logic        fc_batch_end,
    output logic        busy,
    output logic        sample_done,
    output logic        batch_done,
    output logic [5:0]  sample_cnt,
    output logic        err
);

    fc_state_t   state, state_nxt;
    logic        w_loaded;
    logic [31:0] wd;
    logic        wd_expired;
    logic        phase_done;
    logic [5:0]  cnt_inc;
    logic [15:0] base;
    logic [15:0] words;

    assign base       = load_base(state, FRT_CELL, MID_CELL, BCK_CELL);
    assign words      = load_words(state, FRT_CELL, MID_CELL, BCK_CELL);
    assign cnt_inc    = sample_cnt + 6'd1;
    assign wd_expired = (wd == 32'(TIMEOUT - 1));

    fc_load_ctrl u_load (
        .clk        (clk),
        .reset_n    (reset_n),
        .active     (is_load(state)),
        .base       (base),
        .words      (words),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_data   (src_data),
        .ex_we      (ex_we),
        .ex_value   (ex_value),
        .ex_addr    (ex_addr),
        .phase_done (phase_done)
    );

    always_comb begin
        state_nxt      = state;
        weight1        = 1'b0;
        weight2        = 1'b0;
        right_answer   = 1'b0;
        enable         = 1'b0;
        bck_prop_start = 1'b0;
        batch_end      = 1'b0;
        busy           = (state != IDLE);
        err            = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (load_weights || !w_loaded) ? LD_W1 : LD_IN;
            end
            LD_W1: begin
                weight1 = 1'b1;
                if (phase_done) state_nxt = LD_W2;
            end
            LD_W2: begin
                weight2 = 1'b1;
                if (phase_done) state_nxt = LD_IN;
            end
            LD_IN: begin
                if (phase_done) state_nxt = LD_ANS;
            end
            LD_ANS: begin
                right_answer = 1'b1;
                if (phase_done) state_nxt = SETTLE;
            end
            SETTLE: state_nxt = FWD;
            FWD: begin
                enable = 1'b1;
                if (all_end)         state_nxt = BWD;
                else if (wd_expired) state_nxt = ERR;
            end
            BWD: begin
                bck_prop_start = 1'b1;
                if (fc_bck_prop_end)
                    state_nxt = (cnt_inc == 6'(BATCH_SIZE)) ? BATCH : IDLE;
                else if (wd_expired)
                    state_nxt = ERR;
            end
            BATCH: begin
                batch_end = 1'b1;
                if (fc_batch_end)    state_nxt = IDLE;
                else if (wd_expired) state_nxt = ERR;
            end
            ERR:     err = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            w_loaded    <= 1'b0;
            sample_cnt  <= '0;
            sample_done <= 1'b0;
            batch_done  <= 1'b0;
            wd          <= '0;
        end else begin
            state       <= state_nxt;
            sample_done <= (state == BWD) && fc_bck_prop_end;
            batch_done  <= (state == BATCH) && fc_batch_end;
            if (state == LD_W2 && phase_done)
                w_loaded <= 1'b1;
            if (state == BWD && fc_bck_prop_end)
                sample_cnt <= cnt_inc;
            else if (state == BATCH && fc_batch_end)
                sample_cnt <= '0;
            // Restarting on every state change gives each command a fresh budget.
            wd <= (state_nxt != state) ? '0 : wd + 32'd1;
        end
    end

endmodule

// File: tb/tb_fc_train_sequencer.sv
// Randomized bench for fc_train_sequencer with a cycle-level behavioural model.
module tb_fc_train_sequencer;

    localparam int FRT = 14, MID = 10, BCK = 5, BSZ = 2, TMO = 20;
    localparam int M_IDLE = 0, M_LOAD = 1, M_SETTLE = 2, M_FWD = 3, M_BWD = 4, M_BATCH = 5, M_ERR = 6;

    typedef struct packed { logic [15:0] addr; logic [2:0] sel; } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, load_weights = 1'b0;
    logic src_valid = 1'b0, src_ready;
    logic [15:0] src_data = 16'd0;
    logic ex_we, weight1, weight2, right_answer;
    logic [15:0] ex_value, ex_addr;
    logic enable, bck_prop_start, batch_end;
    logic all_end = 1'b0, fc_bck_prop_end = 1'b0, fc_batch_end = 1'b0;
    logic busy, sample_done, batch_done, err;
    logic [5:0] sample_cnt;

    fc_train_sequencer #(.FRT_CELL(FRT), .MID_CELL(MID), .BCK_CELL(BCK),
                         .BATCH_SIZE(BSZ), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .load_weights(load_weights),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .ex_we(ex_we), .ex_value(ex_value), .ex_addr(ex_addr),
        .weight1(weight1), .weight2(weight2), .right_answer(right_answer),
        .enable(enable), .bck_prop_start(bck_prop_start), .batch_end(batch_end),
        .all_end(all_end), .fc_bck_prop_end(fc_bck_prop_end), .fc_batch_end(fc_batch_end),
        .busy(busy), .sample_done(sample_done), .batch_done(batch_done),
        .sample_cnt(sample_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int vmode = 0, fwd_dly = 3, bck_dly = 2, bat_dly = 2;
    bit noise = 1'b0, no_all_end = 1'b0;
    int n_w1, n_w2, n_in, n_ans, w1_first, w1_last, in_first, in_last, ans_first, ans_last;
    int en_cycles, bk_cycles, be_cycles, sd_pulses, bd_pulses, w12_cycles;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_stats();
        n_w1 = 0; n_w2 = 0; n_in = 0; n_ans = 0;
        w1_first = -1; w1_last = -1; in_first = -1; in_last = -1; ans_first = -1; ans_last = -1;
        en_cycles = 0; bk_cycles = 0; be_cycles = 0; sd_pulses = 0; bd_pulses = 0; w12_cycles = 0;
    endtask

    // Source stream: fresh random data each cycle, valid pattern chosen by vmode.
    initial begin
        bit ph = 1'b0;
        forever begin
            tick();
            ph = !ph;
            case (vmode)
                0:       src_valid = 1'b1;
                1:       src_valid = ph;
                default: src_valid = 1'($urandom_range(0, 1));
            endcase
            src_data = 16'($urandom);
        end
    end

    // FC responder: done inputs after a programmed number of command cycles, random noise otherwise.
    initial begin
        int en_age = 0, bk_age = 0, ba_age = 0;
        forever begin
            tick();
            en_age = enable ? en_age + 1 : 0;
            bk_age = bck_prop_start ? bk_age + 1 : 0;
            ba_age = batch_end ? ba_age + 1 : 0;
            all_end         = enable ? (en_age == fwd_dly && !no_all_end)
                                     : (noise && $urandom_range(0, 5) == 0);
            fc_bck_prop_end = bck_prop_start ? (bk_age == bck_dly)
                                             : (noise && $urandom_range(0, 5) == 0);
            fc_batch_end    = batch_end ? (ba_age == bat_dly)
                                        : (noise && $urandom_range(0, 5) == 0);
        end
    end

    // Behavioural model and per-cycle comparison.
    int  m_mode = M_IDLE, m_cnt = 0, m_wd = 0;
    bit  m_wl = 1'b0, m_sd = 1'b0, m_bd = 1'b0, m_we = 1'b0;
    wr_t plan_q[$];
    logic [15:0] val_q[$];

    initial begin
        wr_t w;
        logic [15:0] v;
        bit last_wr, xfer, n_sd, n_bd, n_we;
        @(posedge clk);
        forever begin
            @(negedge clk);
            last_wr = 1'b0;
            chk("busy", int'(busy), int'(m_mode != M_IDLE));
            chk("enable", int'(enable), int'(m_mode == M_FWD));
            chk("bck_prop_start", int'(bck_prop_start), int'(m_mode == M_BWD));
            chk("batch_end", int'(batch_end), int'(m_mode == M_BATCH));
            chk("err", int'(err), int'(m_mode == M_ERR));
            chk("sample_done", int'(sample_done), int'(m_sd));
            chk("batch_done", int'(batch_done), int'(m_bd));
            chk("sample_cnt", int'(sample_cnt), m_cnt);
            chk("ex_we", int'(ex_we), int'(m_we));
            if (ex_we && m_we) begin
                w = plan_q.pop_front();
                v = val_q.pop_front();
                chk("ex_addr", int'(ex_addr), int'(w.addr));
                chk("ex_value", int'(ex_value), int'(v));
                chk("select", int'({right_answer, weight2, weight1}), int'(w.sel));
                case (w.sel)
                    3'b001: begin if (n_w1 == 0) w1_first = ex_addr; w1_last = ex_addr; n_w1++; end
                    3'b010: n_w2++;
                    3'b100: begin if (n_ans == 0) ans_first = ex_addr; ans_last = ex_addr; n_ans++; end
                    default: begin if (n_in == 0) in_first = ex_addr; in_last = ex_addr; n_in++; end
                endcase
                if (w.sel == 3'b010 && (plan_q.size() == 0 || plan_q[0].sel != 3'b010)) m_wl = 1'b1;
                last_wr = (plan_q.size() == 0);
            end else if (m_mode != M_LOAD) begin
                chk("select_outside_load", int'({right_answer, weight2, weight1}), 0);
            end
            if (src_ready)
                chk("src_ready_legal", int'(m_mode == M_LOAD && plan_q.size() > val_q.size()), 1);
            if (enable) en_cycles++;
            if (bck_prop_start) bk_cycles++;
            if (batch_end) be_cycles++;
            if (sample_done) sd_pulses++;
            if (batch_done) bd_pulses++;
            if (weight1 || weight2) w12_cycles++;

            // Expected outputs for the next cycle from this cycle's inputs.
            n_sd = 1'b0; n_bd = 1'b0;
            xfer = src_valid && src_ready && m_mode == M_LOAD && plan_q.size() > val_q.size();
            n_we = xfer;
            if (xfer) val_q.push_back(src_data);
            case (m_mode)
                M_IDLE: if (start) begin
                    if (load_weights || !m_wl) begin
                        for (int i = 0; i < FRT * MID; i++) begin w.addr = 16'(FRT + i); w.sel = 3'b001; plan_q.push_back(w); end
                        for (int i = 0; i < MID * BCK; i++) begin w.addr = 16'(MID + i); w.sel = 3'b010; plan_q.push_back(w); end
                    end
                    for (int i = 0; i < FRT; i++) begin w.addr = 16'(i); w.sel = 3'b000; plan_q.push_back(w); end
                    for (int i = 0; i < BCK; i++) begin w.addr = 16'(BCK + i); w.sel = 3'b100; plan_q.push_back(w); end
                    m_mode = M_LOAD;
                end
                M_LOAD:   if (last_wr) m_mode = M_SETTLE;
                M_SETTLE: begin m_mode = M_FWD; m_wd = 0; end
                M_FWD: begin
                    if (all_end) begin m_mode = M_BWD; m_wd = 0; end
                    else begin m_wd++; if (m_wd == TMO) m_mode = M_ERR; end
                end
                M_BWD: begin
                    if (fc_bck_prop_end) begin
                        m_cnt++; n_sd = 1'b1; m_wd = 0;
                        m_mode = (m_cnt == BSZ) ? M_BATCH : M_IDLE;
                    end else begin m_wd++; if (m_wd == TMO) m_mode = M_ERR; end
                end
                M_BATCH: begin
                    if (fc_batch_end) begin m_cnt = 0; n_bd = 1'b1; m_mode = M_IDLE; end
                    else begin m_wd++; if (m_wd == TMO) m_mode = M_ERR; end
                end
                default: ;
            endcase
            if (!reset_n) begin
                m_mode = M_IDLE; m_cnt = 0; m_wl = 1'b0;
                n_sd = 1'b0; n_bd = 1'b0; n_we = 1'b0;
                plan_q.delete(); val_q.delete();
            end
            m_sd = n_sd; m_bd = n_bd; m_we = n_we;
        end
    end

    task automatic run_sample(input bit ld);
        int k;
        start = 1'b1; load_weights = ld;
        tick();
        start = 1'b0;
        k = 0;
        while (busy && k < 4000) begin
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            load_weights = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        start = 1'b0;
        chk("sample_completes", int'(k < 4000), 1);
        tick();
    endtask

    initial begin
        int k;
        clear_stats();
        tick(); tick();
        reset_n = 1'b1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_sample_cnt", int'(sample_cnt), 0);
        chk("reset_ex_we", int'(ex_we), 0);
        chk("reset_src_ready", int'(src_ready), 0);

        // First sample: weights never loaded, so a full load happens despite load_weights=0.
        vmode = 0; fwd_dly = 3; bck_dly = 2; bat_dly = 2;
        clear_stats();
        run_sample(1'b0);
        chk("s1_w1_writes", n_w1, 140);
        chk("s1_w2_writes", n_w2, 50);
        chk("s1_in_writes", n_in, 14);
        chk("s1_ans_writes", n_ans, 5);
        chk("s1_w1_first_addr", w1_first, 14);
        chk("s1_w1_last_addr", w1_last, 153);
        chk("s1_ans_first_addr", ans_first, 5);
        chk("s1_ans_last_addr", ans_last, 9);
        chk("s1_enable_width", en_cycles, 3);
        chk("s1_bck_width", bk_cycles, 2);
        chk("s1_sample_done_pulses", sd_pulses, 1);
        chk("s1_sample_cnt", int'(sample_cnt), 1);

        // Second sample: inputs only, valid every other cycle, closes the batch.
        vmode = 1;
        clear_stats();
        run_sample(1'b0);
        chk("s2_w1_writes", n_w1, 0);
        chk("s2_w2_writes", n_w2, 0);
        chk("s2_weight_sel_cycles", w12_cycles, 0);
        chk("s2_in_writes", n_in, 14);
        chk("s2_in_first_addr", in_first, 0);
        chk("s2_in_last_addr", in_last, 13);
        chk("s2_ans_writes", n_ans, 5);
        chk("s2_batch_end_width", be_cycles, 2);
        chk("s2_batch_done_pulses", bd_pulses, 1);
        chk("s2_sample_cnt", int'(sample_cnt), 0);

        // Random samples with noise on done inputs and start.
        noise = 1'b1;
        for (int s = 0; s < 8; s++) begin
            vmode = $urandom_range(0, 2);
            fwd_dly = $urandom_range(1, 6);
            bck_dly = $urandom_range(1, 6);
            bat_dly = $urandom_range(1, 6);
            run_sample(1'($urandom_range(0, 1)));
        end
        noise = 1'b0;

        // Watchdog: all_end never arrives.
        no_all_end = 1'b1; vmode = 0;
        clear_stats();
        start = 1'b1; load_weights = 1'b0;
        tick();
        start = 1'b0;
        k = 0;
        while (!err && k < 1000) begin tick(); k++; end
        chk("wd_err_set", int'(err), 1);
        chk("wd_enable_width", en_cycles, TMO);
        chk("wd_enable_low", int'(enable), 0);
        tick(); tick();
        chk("wd_err_sticky", int'(err), 1);
        no_all_end = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("err_cleared_by_reset", int'(err), 0);
        chk("idle_after_reset", int'(busy), 0);

        // Reset in the middle of the W2 load.
        start = 1'b1; load_weights = 1'b0;
        tick();
        start = 1'b0;
        k = 0;
        while (!weight2 && k < 2000) begin tick(); k++; end
        chk("reached_ld_w2", int'(weight2), 1);
        tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midload_reset_busy", int'(busy), 0);
        chk("midload_reset_ex_we", int'(ex_we), 0);
        chk("midload_reset_weight2", int'(weight2), 0);
        chk("midload_reset_src_ready", int'(src_ready), 0);
        chk("midload_reset_enable", int'(enable), 0);

        // Weights-loaded flag was cleared, so W1 reloads again.
        clear_stats();
        run_sample(1'b0);
        chk("post_reset_w1_writes", n_w1, 140);
        chk("post_reset_sample_cnt", int'(sample_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
